muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, owning the HI/LO registers.
//   It is the producing end of the start/busy interface that the hazard unit consumes:
//   the hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while (start|busy).
//   Results are computed at issue, held for a fixed latency, then committed to HI/LO.
// PARAMETERS
//   MUL_LAT  5   cycles busy stays high for MULT/MULTU (>=1)
//   DIV_LAT  10  cycles busy stays high for DIV/DIVU (>=1)
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   synchronous active-low reset
//   start   in   1   issue strobe; high for exactly the cycle a mult/div is in EX
//   op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   a       in   32  rs operand (forwarded), sampled with start
//   b       in   32  rt operand (forwarded), sampled with start
//   hi_we   in   1   MTHI write enable
//   lo_we   in   1   MTLO write enable
//   wdata   in   32  MTHI/MTLO data
//   busy    out  1   operation in flight (registered)
//   hi      out  32  HI register (registered, read by MFHI)
//   lo      out  32  LO register (registered, read by MFLO)
// BEHAVIOUR
//   Reset (rst_n=0 at a posedge): state=IDLE, busy=0, hi=0, lo=0, counter=0, pending results
//     discarded. Applies mid-operation too: no later HI/LO commit from the aborted op.
//   FSM: IDLE, RUN.
//     IDLE & start: capture op/a/b, compute pending {hi_p,lo_p}, counter <= LAT(op),
//       go RUN. busy=1 from the next cycle.
//     RUN: counter decrements each cycle; at the edge where counter==1, commit
//       {hi,lo}<=pending (unless suppressed), busy<=0, go IDLE.
//     Timing: start in cycle 0 -> busy=1 in cycles 1..LAT -> new hi/lo visible and
//       busy=0 in cycle LAT+1. Back-to-back: a start in cycle LAT+1 is accepted.
//   Arithmetic:
//     MULT: signed 32x32 -> 64; HI=prod[63:32], LO=prod[31:0]. MULTU: unsigned.
//     DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//       0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//     DIVU: unsigned quotient/remainder.
//     Divide by zero (b==0, DIV or DIVU): full DIV_LAT busy window, HI/LO NOT written.
//   MTHI/MTLO: in IDLE without start, hi_we/lo_we write wdata at the edge; both may be
//     high together (both written). Visible next cycle.
//   Conflicts (hazard logic prevents; behaviour still fixed):
//     start while RUN: ignored; the in-flight op completes unchanged.
//     hi_we/lo_we while RUN or in same cycle as start: ignored.
//     start with op/a/b changing after the start cycle: no effect (operands latched).
//   busy never glitches: a flop output, combinationally independent of the inputs.
// TESTING
//   1 rst_n=0 for 2 cycles then 1 -> busy=0, hi=0, lo=0; idle with no strobes keeps them.
//   2 MULT a=0xFFFFFFFD b=7 -> busy=1 exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB;
//     MULTU a=0xFFFFFFFF b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
//   3 DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF;
//     DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 7/0 -> HI/LO unchanged.
//   4 hi_we=1 wdata=0x1234 then lo_we=1 wdata=0x5678 -> hi=0x1234, lo=0x5678 a cycle after each;
//     hi_we with start same cycle -> hi unchanged by the write, holds mult result after.
//   5 start in cycle LAT+1 of a MULT with new operands -> accepted, second result correct;
//     start pulsed during RUN -> ignored, first result committed at original time.
//   6 start MULT 3*4, rst_n=0 in cycle 3 -> busy=0, hi=lo=0 next cycle, never become 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at issue, held for a fixed latency, then committed.
module muldiv_unit #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          commit_q, commit_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   hi_p_q, hi_p_d, lo_p_q, lo_p_d;

   logic          is_div, is_signed;
   logic          a_neg, b_neg;
   logic [31:0]   a_mag, b_mag, b_safe;
   logic [63:0]   prod_mag, prod;
   logic [31:0]   q_mag, r_mag, quot, rem;

   assign is_div    = op[1];
   assign is_signed = ~op[0];

   // Signed ops share the unsigned datapath via sign/magnitude; this also makes
   // 0x80000000 / -1 wrap to 0x80000000 without a special case.
   always_comb begin
      a_neg    = is_signed & a[31];
      b_neg    = is_signed & b[31];
      a_mag    = a_neg ? (~a + 32'd1) : a;
      b_mag    = b_neg ? (~b + 32'd1) : b;
      prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
      prod     = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;
      b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag    = a_mag / b_safe;
      r_mag    = a_mag % b_safe;
      quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      commit_d = commit_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_p_d   = hi_p_q;
      lo_p_d   = lo_p_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               busy_d   = 1'b1;
               cnt_d    = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
               hi_p_d   = is_div ? rem  : prod[63:32];
               lo_p_d   = is_div ? quot : prod[31:0];
               commit_d = ~(is_div && (b == 32'd0));
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               if (commit_q) begin
                  hi_d = hi_p_q;
                  lo_d = lo_p_q;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         commit_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         hi_p_q   <= '0;
         lo_p_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         commit_q <= commit_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_p_q   <= hi_p_d;
         lo_p_q   <= lo_p_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences, then random operations against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi, m_lo;

   muldiv_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          keep;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   function automatic int lat_of(input logic [1:0] o);
      return o[1] ? 10 : 5;
   endfunction

   // Plain-arithmetic reference: {HI, LO} after the op, given the current HI/LO.
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] ch,
                                           input logic [31:0] cl);
      longint sx, sy, q, r;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         2'd0: begin p = sx * sy; return p; end
         2'd1: begin p = ux * uy; return p; end
         2'd2: begin
            if (y == 0) return {ch, cl};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 0) return {ch, cl};
            p = ux / uy;
            ux = ux % uy;
            return {ux[31:0], p[31:0]};
         end
      endcase
   endfunction

   // Issue one op at the current cycle and follow it to completion.
   task automatic run_op(input string nm, input logic [1:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input logic [31:0] e_hi,
                         input logic [31:0] e_lo);
      int lat;
      int bad;
      lat   = lat_of(t_op);
      start = 1'b1;
      op    = t_op;
      a     = t_a;
      b     = t_b;
      tick();
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      bad   = 0;
      for (int i = 1; i <= lat; i++) begin
         if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad++;
         if (i < lat) tick();
      end
      chk({nm, " busy window"}, 32'(bad), 32'd0);
      tick();
      chk({nm, " busy end"}, {31'd0, busy}, 32'd0);
      chk({nm, " hi"}, hi, e_hi);
      chk({nm, " lo"}, lo, e_lo);
      m_hi = e_hi;
      m_lo = e_lo;
      $display("op %-12s op=%0d a=%h b=%h -> hi=%h lo=%h", nm, t_op, t_a, t_b, hi, lo);
   endtask

   initial begin
      int bad;
      logic [63:0] r;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;

      vecs[0] = '{"mult_neg",  2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{"multu_max", 2'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[2] = '{"div_neg",   2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3] = '{"div_ovf",   2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[4] = '{"divu_zero", 2'd3, 32'd7,        32'd0,        32'h0,        32'h0,        1'b1};
      vecs[5] = '{"divu_100_7",2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[6] = '{"div_7_m2",  2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      vecs[7] = '{"mult_min2", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

      rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

      // Reset and idle hold
      tick(); tick();
      rst_n = 1'b1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      repeat (3) tick();
      chk("idle hi", hi, 32'd0);
      chk("idle lo", lo, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;

      // Directed vectors, issued back-to-back
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].keep) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo);
         else run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      end

      // MTHI then MTLO, then both together
      hi_we = 1'b1; wdata = 32'h1234; tick(); hi_we = 1'b0;
      chk("mthi hi", hi, 32'h1234);
      lo_we = 1'b1; wdata = 32'h5678; tick(); lo_we = 1'b0;
      chk("mtlo lo", lo, 32'h5678);
      chk("mtlo hi kept", hi, 32'h1234);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA; tick(); hi_we = 1'b0; lo_we = 1'b0;
      chk("mthilo hi", hi, 32'hAA);
      chk("mthilo lo", lo, 32'hAA);
      $display("mt writes hi=%h lo=%h", hi, lo);

      // hi_we with start, lo_we during RUN: both ignored
      start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4; hi_we = 1'b1; wdata = 32'hDEAD;
      tick();
      start = 1'b0; hi_we = 1'b0;
      chk("we+start hi", hi, 32'hAA);
      lo_we = 1'b1; wdata = 32'hBEEF; tick(); lo_we = 1'b0;
      chk("we in run lo", lo, 32'hAA);
      repeat (4) tick();
      chk("we+start busy end", {31'd0, busy}, 32'd0);
      chk("we+start hi res", hi, 32'd0);
      chk("we+start lo res", lo, 32'd12);
      $display("mult 3*4 with stray writes hi=%h lo=%h", hi, lo);

      // start pulsed during RUN is ignored
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
      tick(); start = 1'b0;
      tick();
      start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd3;
      tick(); start = 1'b0;
      tick(); tick();
      chk("ign start busy c5", {31'd0, busy}, 32'd1);
      chk("ign start lo c5", lo, 32'd12);
      tick();
      chk("ign start busy c6", {31'd0, busy}, 32'd0);
      chk("ign start lo", lo, 32'd30);
      chk("ign start hi", hi, 32'd0);
      bad = 0;
      repeat (12) begin
         tick();
         if (busy !== 1'b0 || lo !== 32'd30 || hi !== 32'd0) bad++;
      end
      chk("ign start no relaunch", 32'(bad), 32'd0);
      $display("mult 5*6 with ignored start hi=%h lo=%h", hi, lo);

      // Reset aborts an in-flight MULT
      start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
      tick(); start = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      bad = 0;
      repeat (8) begin
         tick();
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
      end
      chk("abort no commit", 32'(bad), 32'd0);
      $display("reset abort hi=%h lo=%h", hi, lo);
      m_hi = 32'd0;
      m_lo = 32'd0;

      // Random ops against the reference model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            hi_we = 1'($urandom);
            lo_we = ~hi_we | 1'($urandom);
            wdata = $urandom;
            tick();
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            hi_we = 1'b0; lo_we = 1'b0;
            chk("rnd mt hi", hi, m_hi);
            chk("rnd mt lo", lo, m_lo);
         end
         r_op = 2'($urandom);
         r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
         case ($urandom_range(0, 5))
            0: r_b = 32'd0;
            1: r_b = 32'hFFFFFFFF;
            2: r_b = 32'($urandom_range(1, 20));
            default: r_b = $urandom;
         endcase
         r = ref_res(r_op, r_a, r_b, m_hi, m_lo);
         run_op("random", r_op, r_a, r_b, r[63:32], r[31:0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
